// File: rtl/octree_mem_arbiter.sv
// -----------------------------------------------------------------------------
// octree_mem_arbiter
//
// Shares the single main-memory SRAM port between the Octree sub-blocks
// (port 0 = searcher, port 1 = updater, remaining ports for future engines).
// A requester wins the SRAM in IDLE, and its beat goes to the SRAM in the same
// cycle. A burst (first beat with req_last=0) locks the port until req_last or
// MAX_BURST beats. Read data returns on rsp_valid/rsp_data RD_LATENCY cycles
// after the accepting edge, tagged to the issuing port.
//
// Handshake: a beat transfers on the rising edge where req_valid[p] and
// req_ready[p] are both high. req_ready does not depend on this cycle's
// req_last/req_we, and a port must hold its beat stable until it transfers.
//
// Configuration macro: OCTREE_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority in IDLE, lowest port index wins
//   undefined -> round-robin starting at rr_ptr (default)
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid/ready   per-port request handshake
//   req_we/req_last   per-port write flag and last-beat flag
//   req_addr/wdata    packed per-port address and write data
//   rsp_valid         one-hot read-data valid
//   rsp_data          read data, shared by all ports
//   mem_sram_*        SRAM macro port (CEN/GWEN active low)
//   dbg_state         FSM state (0 = IDLE, 1 = LOCKED)
// -----------------------------------------------------------------------------
module octree_mem_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_BUS_WIDTH = 64,
  parameter int DATA_BUS_WIDTH = 64,
  parameter int RD_LATENCY     = 1,
  parameter int MAX_BURST      = 9,
  parameter int PORT_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                req_valid,
  output logic [NUM_PORTS-1:0]                req_ready,
  input  logic [NUM_PORTS-1:0]                req_we,
  input  logic [NUM_PORTS-1:0]                req_last,
  input  logic [NUM_PORTS*ADDR_BUS_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_BUS_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]                rsp_valid,
  output logic [DATA_BUS_WIDTH-1:0]           rsp_data,
  output logic                                mem_sram_CEN,
  output logic                                mem_sram_GWEN,
  output logic [ADDR_BUS_WIDTH-1:0]           mem_sram_A,
  output logic [DATA_BUS_WIDTH-1:0]           mem_sram_D,
  input  logic [DATA_BUS_WIDTH-1:0]           mem_sram_Q,
  output logic                                dbg_state
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [PORT_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [PORT_W-1:0] winner, sel;
  logic              winner_found, sel_en, accept, sel_we, sel_last, release_lock;

  // Read-return pipeline: one {valid, port} entry per cycle of SRAM latency.
  logic              pipe_v [RD_LATENCY];
  logic [PORT_W-1:0] pipe_p [RD_LATENCY];

`ifdef OCTREE_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest asserted index is written last.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        winner       = PORT_W'(i);
        winner_found = 1'b1;
      end
    end
  end
`else
  logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!winner_found && req_valid[(int'(rr_ptr_q) + i) % NUM_PORTS]) begin
        winner       = PORT_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
        winner_found = 1'b1;
      end
    end
  end

  // On release, the port after the one just served gets first pick.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (release_lock) rr_ptr_d = (sel == LAST_PORT) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  // While LOCKED the owner keeps the grant even when its valid is low, so
  // nobody else can slip in during an owner stall.
  always_comb begin
    if (state_q == ST_LOCKED) begin
      sel    = owner_q;
      sel_en = 1'b1;
    end else begin
      sel    = winner;
      sel_en = winner_found;
    end
  end

  assign accept    = sel_en & req_valid[sel] & ~rst;
  assign sel_we    = req_we[sel];
  assign sel_last  = req_last[sel];
  assign req_ready = (sel_en && !rst) ? (NUM_PORTS'(1) << sel) : '0;

  assign mem_sram_CEN  = ~accept;
  assign mem_sram_GWEN = ~(accept & sel_we);
  assign mem_sram_A    = accept ? req_addr[sel*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH] : '0;
  assign mem_sram_D    = (accept && sel_we) ? req_wdata[sel*DATA_BUS_WIDTH +: DATA_BUS_WIDTH] : '0;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    beat_cnt_d   = beat_cnt_q;
    release_lock = 1'b0;
    if (accept) begin
      if (state_q == ST_IDLE) begin
        if (sel_last || MAX_BURST == 1) begin
          release_lock = 1'b1;
        end else begin
          state_d    = ST_LOCKED;
          owner_d    = sel;
          beat_cnt_d = CNT_W'(1);
        end
      end else begin
        // This beat brings the count to MAX_BURST: force the release.
        if (sel_last || beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
          state_d      = ST_IDLE;
          beat_cnt_d   = '0;
          release_lock = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_p[i] <= '0;
      end
    end else begin
      pipe_v[0] <= accept & ~sel_we;
      pipe_p[0] <= sel;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_p[i] <= pipe_p[i-1];
      end
    end
  end

  assign rsp_valid = (pipe_v[RD_LATENCY-1] && !rst) ? (NUM_PORTS'(1) << pipe_p[RD_LATENCY-1]) : '0;
  assign rsp_data  = (pipe_v[RD_LATENCY-1] && !rst) ? mem_sram_Q : '0;
  assign dbg_state = state_q;

endmodule

// File: doc/octree_mem_arbiter.md
# octree_mem_arbiter

N-port arbiter that multiplexes Octree sub-blocks (searcher, updater, future LOD/feature engines) onto the single main-memory SRAM port. Requesters issue single-beat or burst accesses through a valid/ready handshake. The arbiter routes read data back to the issuing port after a configurable SRAM read latency. It replaces the static select-driven SRAM mux in the Octree top level and removes the need for Control to sequence memory ownership.

## Interface
- NUM_PORTS, 4: number of requesters; port 0 = searcher, 1 = updater.
- ADDR_BUS_WIDTH, 64: SRAM address width.
- DATA_BUS_WIDTH, 64: SRAM data width.
- RD_LATENCY, 1: cycles from read issue to valid mem_sram_Q, 1..4.
- MAX_BURST, 9: maximum beats held under one lock (FEATURE_LENTH).
- PORT_W, $clog2(NUM_PORTS): port-index width, derived.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port accept; a beat transfers when valid & ready.
- req_we  in  NUM_PORTS  1 = write, 0 = read.
- req_last  in  NUM_PORTS  1 = final beat of burst.
- req_addr  in  NUM_PORTS×ADDR_BUS_WIDTH  packed per-port address.
- req_wdata  in  NUM_PORTS×DATA_BUS_WIDTH  packed per-port write data.
- rsp_valid  out  NUM_PORTS  one-hot read-data valid.
- rsp_data  out  DATA_BUS_WIDTH  read data, shared by all ports.
- mem_sram_CEN  out  1  chip enable, active low.
- mem_sram_GWEN  out  1  write enable, active low.
- mem_sram_A  out  ADDR_BUS_WIDTH  address.
- mem_sram_D  out  DATA_BUS_WIDTH  write data.
- mem_sram_Q  in  DATA_BUS_WIDTH  read data.

## Operation
- States: IDLE (no owner) and LOCKED (owner register valid). Round-robin pointer rr_ptr (PORT_W bits), beat counter beat_cnt ($clog2(MAX_BURST+1) bits).
- IDLE:
  - Combinational winner = first asserted req_valid scanning rr_ptr, rr_ptr+1, … modulo NUM_PORTS.
  - Only the winner sees req_ready=1, and its beat is issued to the SRAM the same cycle.
  - If that beat has req_last=0, go to LOCKED with owner=winner and beat_cnt=1.
  - If req_last=1, stay IDLE and set rr_ptr=winner+1 (wrapping to 0 at NUM_PORTS).
- LOCKED:
  - Only the owner gets req_ready=1; all other ports get 0.
  - Each accepted beat increments beat_cnt.
  - Release to IDLE, with rr_ptr=owner+1, when the owner's accepted beat has req_last=1 or beat_cnt reaches MAX_BURST, whichever comes first.
  - Forced release on MAX_BURST: any further owner beats re-arbitrate as a new burst.
- Owner deasserts req_valid while LOCKED: the lock is held, SRAM idles with CEN=1, and no other port is granted.
- SRAM drive for an accepted beat:
  - CEN=0, A=req_addr[p], GWEN=~req_we[p].
  - D=req_wdata[p] on writes, 0 on reads.
  - With no accepted beat: CEN=1, GWEN=1, A=0, D=0.
- Read return:
  - A shift pipeline of depth RD_LATENCY carries {valid, port}.
  - At its tail: rsp_valid[port]=1 and rsp_data=mem_sram_Q.
  - Otherwise rsp_valid=0 and rsp_data=0.
  - Writes never produce a response.
- Simultaneous requests: exactly one grant per cycle. No port waits more than NUM_PORTS-1 bursts.

## Timing
- Grant and SRAM issue are combinational from req_valid in IDLE: 0-cycle request-to-SRAM latency.
- Read response arrives exactly RD_LATENCY cycles after the accepting edge. Back-to-back reads give one response per cycle.
- Reset (rst=1, asynchronous):
  - State → IDLE, rr_ptr=0, beat_cnt=0, pipeline cleared.
  - While rst is high: req_ready=0, rsp_valid=0, rsp_data=0, CEN=1, GWEN=1, A=0, D=0.
- Reset mid-burst drops the lock. In-flight reads are discarded and no rsp_valid is emitted for them.
- The first grant is possible in the first cycle after rst deasserts.

## Configuration
- OCTREE_ARB_FIXED_PRIO_EN defined: fixed priority, lowest port index wins in IDLE. rr_ptr is not implemented, and locking and MAX_BURST behave identically.
- OCTREE_ARB_FIXED_PRIO_EN undefined (default): round-robin as specified above.

## Test plan
- Single read: port 1 reads A=500 with last=1 and mem_sram_Q=0xABCD at RD_LATENCY=1 → CEN=0 and GWEN=1 in cycle 0; rsp_valid=4'b0010 and rsp_data=0xABCD in cycle 1.
- Burst lock: port 0 issues 9 reads from addr 400 with last on beat 9 while port 1 holds valid → port 1 ready stays 0 for 9 cycles, then is granted in cycle 10.
- Round-robin: all 4 ports request single beats continuously from reset → grant order 0,1,2,3,0,… With FIXED_PRIO_EN: port 0 only.
- MAX_BURST: port 2 streams 12 beats with last=0 and port 3 is valid → forced release after beat 9, then port 3 is granted.
- Owner stall: port 0 holds the lock and drops valid for 3 cycles → CEN=1 for those 3 cycles, no other grant, burst resumes afterwards.
- Reset mid-burst: rst asserted 1 cycle after a read issues at RD_LATENCY=2 → no rsp_valid; after release, port 1 is granted as first requester with rr_ptr=0.
